// File: rtl/dmem_responder.sv
// Data-memory responder: single outstanding word load/store with programmable latency,
// valid/ready on both request and response sides, backed by a word-addressed RAM.
module dmem_responder #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int DEPTH_LOG2 = 7,
    parameter int LAT        = 2
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;

    logic [DATA_W-1:0]   mem [2**DEPTH_LOG2];
    logic [DEPTH_LOG2-1:0] idx;
    logic                acc_err;
    logic                commit;

    assign idx     = addr_q[DEPTH_LOG2+1:2];
    // Misaligned, or any byte-address bit above the RAM window set.
    assign acc_err = (addr_q[1:0] != 2'b00) || ((addr_q >> (DEPTH_LOG2 + 2)) != '0);
    assign commit  = (state_q == WAIT) && (cnt_q == 4'd0);

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign busy       = (state_q != IDLE);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    cnt_d   = CNT_INIT;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                    err_d   = acc_err;
                    rdata_d = (!we_q && !acc_err) ? mem[idx] : '0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                    rdata_d = '0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // RAM is deliberately not reset; a reset before the commit edge leaves it untouched.
    always_ff @(posedge clk) begin
        if (commit && we_q && !acc_err)
            mem[idx] <= wdata_q;
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: latency, errors, backpressure, reset abort, throughput.
module tb_dmem_responder;
    logic        clk = 1'b0;
    logic        rstn;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_err, busy;
    logic [31:0] resp_rdata;

    int vec_cnt = 0;
    int err_cnt = 0;
    int cyc = 0;

    logic        mon_en = 1'b0;
    logic [31:0] mon_q[$];

    dmem_responder #(.ADDR_W(32), .DATA_W(32), .DEPTH_LOG2(7), .LAT(2)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk)
        if (mon_en && resp_valid && resp_ready) mon_q.push_back(resp_rdata);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One full transaction with resp_ready high; returns data and error bit.
    task automatic xact(input logic we, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic er);
        int n;
        logic tmo;
        tmo = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
        n = 0;
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) tmo = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (!resp_valid && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) tmo = 1'b1;
        rd = resp_rdata;
        er = resp_err;
        @(negedge clk);
        chk("xact_timeout", 32'(tmo), 32'd0);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          acc[16];
        int          n;

        rstn = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        resp_ready = 1'b1;
        #12;
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_err", 32'(resp_err), 32'd0);
        @(negedge clk); rstn = 1'b1;
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);

        // 1: sw 0x12345678 to 0x10, cycle-exact latency
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'h12345678;
        @(negedge clk); req_valid = 1'b0;
        chk("t1_ready_e0", 32'(req_ready), 32'd0);
        chk("t1_busy_e0", 32'(busy), 32'd1);
        chk("t1_valid_e0", 32'(resp_valid), 32'd0);
        @(negedge clk);
        chk("t1_valid_e1", 32'(resp_valid), 32'd0);
        @(negedge clk);
        chk("t1_valid_e2", 32'(resp_valid), 32'd1);
        chk("t1_err", 32'(resp_err), 32'd0);
        chk("t1_rdata", resp_rdata, 32'd0);
        @(negedge clk);
        chk("t1_valid_e3", 32'(resp_valid), 32'd0);
        chk("t1_ready_e3", 32'(req_ready), 32'd1);
        xact(1'b0, 32'h10, 32'h0, rd, er);
        chk("t1_lw_data", rd, 32'h12345678);
        chk("t1_lw_err", 32'(er), 32'd0);

        // 2: misaligned
        xact(1'b0, 32'h13, 32'h0, rd, er);
        chk("t2_lw13_err", 32'(er), 32'd1);
        chk("t2_lw13_data", rd, 32'd0);
        xact(1'b1, 32'h20, 32'h11112222, rd, er);
        xact(1'b1, 32'h22, 32'hDEADBEEF, rd, er);
        chk("t2_sw22_err", 32'(er), 32'd1);
        chk("t2_sw22_data", rd, 32'd0);
        xact(1'b0, 32'h20, 32'h0, rd, er);
        chk("t2_lw20_data", rd, 32'h11112222);

        // 3: out of range / last word
        xact(1'b0, 32'h200, 32'h0, rd, er);
        chk("t3_lw200_err", 32'(er), 32'd1);
        chk("t3_lw200_data", rd, 32'd0);
        xact(1'b0, 32'h8000_0000, 32'h0, rd, er);
        chk("t3_lwmsb_err", 32'(er), 32'd1);
        xact(1'b1, 32'h1FC, 32'h5A5A0001, rd, er);
        xact(1'b0, 32'h1FC, 32'h0, rd, er);
        chk("t3_lw1fc_err", 32'(er), 32'd0);
        chk("t3_lw1fc_data", rd, 32'h5A5A0001);

        // 4: backpressure with a stray request pulse
        xact(1'b1, 32'h30, 32'hCAFEF00D, rd, er);
        resp_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h30;
        @(negedge clk); req_valid = 1'b0;
        n = 0;
        while (!resp_valid && n < 20) begin @(negedge clk); n++; end
        chk("t4_timeout", 32'(n >= 20), 32'd0);
        for (int i = 0; i < 5; i++) begin
            chk("t4_valid", 32'(resp_valid), 32'd1);
            chk("t4_rdata", resp_rdata, 32'hCAFEF00D);
            chk("t4_err", 32'(resp_err), 32'd0);
            chk("t4_req_ready", 32'(req_ready), 32'd0);
            chk("t4_busy", 32'(busy), 32'd1);
            if (i == 2) begin
                req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h30; req_wdata = 32'h0;
            end else begin
                req_valid = 1'b0;
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        chk("t4_valid_after", 32'(resp_valid), 32'd0);
        chk("t4_rdata_after", resp_rdata, 32'd0);
        chk("t4_busy_after", 32'(busy), 32'd0);
        xact(1'b0, 32'h30, 32'h0, rd, er);
        chk("t4_mem_kept", rd, 32'hCAFEF00D);

        // 5: reset during WAIT of a store
        xact(1'b1, 32'h40, 32'hAAAA0000, rd, er);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h40; req_wdata = 32'hFFFFFFFF;
        @(negedge clk); req_valid = 1'b0;
        chk("t5_busy_pre", 32'(busy), 32'd1);
        rstn = 1'b0;
        #1;
        chk("t5_busy_rst", 32'(busy), 32'd0);
        chk("t5_valid_rst", 32'(resp_valid), 32'd0);
        chk("t5_ready_rst", 32'(req_ready), 32'd1);
        repeat (3) @(negedge clk);
        chk("t5_valid_hold", 32'(resp_valid), 32'd0);
        rstn = 1'b1;
        @(negedge clk);
        chk("t5_valid_post", 32'(resp_valid), 32'd0);
        xact(1'b0, 32'h40, 32'h0, rd, er);
        chk("t5_mem_kept", rd, 32'hAAAA0000);

        // 6: throughput, alternating sw/lw on 0x00..0x1C
        mon_q.delete();
        resp_ready = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;
        for (int k = 0; k < 16; k++) begin
            req_valid = 1'b1;
            req_we    = (k % 2 == 0);
            req_addr  = 32'((k / 2) * 4);
            req_wdata = 32'hA5000000 | 32'(k / 2);
            n = 0;
            while (!req_ready && n < 20) begin @(negedge clk); n++; end
            chk("t6_accept_tmo", 32'(n >= 20), 32'd0);
            acc[k] = cyc;
            if (k > 0) chk("t6_gap", 32'(acc[k] - acc[k-1]), 32'd4);
            @(negedge clk);
        end
        req_valid = 1'b0;
        repeat (6) @(negedge clk);
        mon_en = 1'b0;
        chk("t6_resp_count", 32'(mon_q.size()), 32'd16);
        if (mon_q.size() == 16)
            for (int k = 1; k < 16; k += 2)
                chk("t6_lw_data", mon_q[k], 32'hA5000000 | 32'(k / 2));

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
